ip_tx_framer: RTL
=================

// Module: ip_tx_framer
// PURPOSE
//  Hand-written RTL replacement for the HLS IP transmit stage. Sits between the ros2 core's
//  byte TX FIFO (siso) and the ip-layer transmit port of verilog_ethernet. Parses a framed
//  byte stream (descriptor + payload), issues one IP header handshake per frame, then
//  streams the payload as 8-bit AXI-Stream with TLAST on the final byte.
// PARAMETERS
//  MAX_PAYLOAD  1480  largest accepted payload length L in bytes; larger frames are dropped
//  IP_HDR_LEN   20    added to L to form the IPv4 total-length field
//  DEF_DSCP     6'd0  DSCP value driven in tx_hdr
// PORTS
//  ap_clk              in   1    sole clock
//  ap_rst_n            in   1    reset, asynchronous assert, active-low
//  din_V_dout          in   8    FIFO head byte, valid whenever din_V_empty_n=1 (first-word fall-through)
//  din_V_empty_n       in   1    FIFO not empty
//  din_V_read          out  1    pop FIFO head this cycle
//  tx_hdr_valid        out  1    header valid
//  tx_hdr_ready        in   1    header accepted
//  tx_hdr              out  104  {dest_ip[32],src_ip[32],protocol[8],ttl[8],length[16],ecn[2],dscp[6]}
//  tx_payload_TVALID   out  1    payload byte valid
//  tx_payload_TREADY   in   1    sink ready
//  tx_payload_TDATA    out  8    payload byte
//  tx_payload_TLAST    out  1    last payload byte of the frame
//  tx_payload_TKEEP    out  1    constant 1
//  tx_payload_TSTRB    out  1    constant 1
//  drop_pulse          out  1    one-cycle pulse per dropped frame
//  frame_cnt           out  16   frames whose header was accepted; wraps 0xFFFF->0
// BEHAVIOUR
//  Input framing, MSB first: dest_ip(4B) src_ip(4B) protocol(1B) ttl(1B) L(2B), then L payload bytes.
//  Reset values: din_V_read=0, tx_hdr_valid=0, tx_hdr=0, TVALID=0, TLAST=0, TDATA=0, drop_pulse=0,
//   frame_cnt=0; FSM enters S_DESC with byte index 0.
//  FSM:
//   S_DESC  : din_V_read=din_V_empty_n; each popped byte shifts into the descriptor register and
//             the index increments. After byte 12: L==0 or L>MAX_PAYLOAD -> S_DROP (drop_pulse=1,
//             remaining count=L); otherwise -> S_HDR.
//   S_HDR   : tx_hdr_valid=1; tx_hdr fields held stable; length=L+IP_HDR_LEN (16-bit, no overflow
//             since L<=MAX_PAYLOAD); ecn=0, dscp=DEF_DSCP. No FIFO reads. On valid&ready:
//             frame_cnt++, remaining=L -> S_PAY.
//   S_PAY   : pop FIFO when head is present and the skid buffer can accept a byte; the popped
//             byte is tagged last when remaining==1. Tagging the last byte -> S_DESC (no FIFO
//             read in that transition cycle).
//   S_DROP  : pop and discard bytes while remaining>0; remaining hits 0 -> S_DESC.
//  Output: payload passes through a 2-entry skid buffer. TVALID/TDATA/TLAST come from registers,
//   with no combinational path from TREADY or FIFO inputs. Latency from FIFO pop to TVALID is 1 cycle.
//   The buffer sustains 1 byte/cycle under constant TREADY=1.
//  AXIS rule: once TVALID=1, TDATA/TLAST hold until TREADY=1.
//  Next frame descriptor parsing may overlap draining of the previous frame in the skid buffer.
//   tx_hdr_valid for frame N+1 may assert before frame N's TLAST has left the buffer.
//  FIFO empty mid-frame: TVALID drops after the buffer drains; the frame resumes when data arrives.
//   No timeout applies.
//  TREADY low for any duration: the buffer fills (2 entries) and FIFO reads stop. No byte is lost.
//  Reset mid-frame: all state is cleared immediately. The surrounding FIFO shares the reset, so
//   stream alignment is restored.
//  frame_cnt counts accepted headers only; dropped frames do not count.
// STRUCTURE
//  Package ip_tx_pkg: state enum {S_DESC,S_HDR,S_PAY,S_DROP}, DESC_BYTES=12, tx_hdr field offsets.
//  Sub-module axis_skid_buf (WIDTH=9: data+last): 2-entry registered AXIS skid buffer with
//   s_ready, used for the payload output.
//  Top holds the FSM, the 96-bit descriptor shift register, the 16-bit remaining counter and
//   frame_cnt.
// TESTING
//  1 Frame dst=C0A80164 src=C0A80101 proto=0x11 ttl=64 L=3 payload AA BB CC, TREADY=1
//    -> tx_hdr length=23, ecn/dscp=0; bytes AA,BB,CC; TLAST only on CC; frame_cnt=1.
//  2 Back-to-back frames L=1 and L=2 preloaded in the FIFO
//    -> 2 headers, 3 payload beats, TLAST after beats 1 and 3; no read while in S_HDR.
//  3 L=0, then a valid L=2 frame -> drop_pulse once, no header for frame 1; frame 2 sent intact.
//  4 L=1500 (>MAX_PAYLOAD) -> drop_pulse; exactly 1500 bytes discarded; the next frame parses correctly.
//  5 Random TREADY (50%) and random FIFO empty gaps over 200 frames
//    -> scoreboard byte-exact; TDATA/TLAST stable while TVALID&!TREADY.
//  6 Assert ap_rst_n=0 during byte 5 of a 10-byte payload
//    -> all outputs 0 while in reset; after release, a fresh frame is handled normally; frame_cnt=0.

Source files
------------

// File: rtl/ip_tx_pkg.sv
// ip_tx_pkg: shared types and constants for the IP transmit framer.
//   state_t      framer FSM states
//   DESC_BYTES   descriptor length in bytes (dest_ip, src_ip, protocol, ttl, L)
//   HDR_*_LSB    bit offsets of the fields inside the 104-bit tx_hdr bus
//   pack_hdr     assembles the tx_hdr bus from its fields
package ip_tx_pkg;

  typedef enum logic [1:0] {
    S_DESC = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam int DESC_BYTES = 12;
  localparam int HDR_W      = 104;

  localparam int HDR_DSCP_LSB  = 0;
  localparam int HDR_ECN_LSB   = 6;
  localparam int HDR_LEN_LSB   = 8;
  localparam int HDR_TTL_LSB   = 24;
  localparam int HDR_PROTO_LSB = 32;
  localparam int HDR_SRC_LSB   = 40;
  localparam int HDR_DST_LSB   = 72;

  function automatic logic [HDR_W-1:0] pack_hdr(
    input logic [31:0] dest_ip,
    input logic [31:0] src_ip,
    input logic [7:0]  protocol,
    input logic [7:0]  ttl,
    input logic [15:0] length,
    input logic [1:0]  ecn,
    input logic [5:0]  dscp
  );
    return {dest_ip, src_ip, protocol, ttl, length, ecn, dscp};
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry registered AXI-Stream skid buffer.
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    upstream handshake; s_ready is a register output
//   s_data             upstream word
//   m_valid/m_ready    downstream handshake; m_valid is a register output
//   m_data             downstream word, held while m_valid & !m_ready
// The output register is the primary entry; the skid register only fills when
// a word is accepted while the output is stalled. s_ready depends solely on
// the skid register, so there is no combinational path from m_ready upstream.
module axis_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             m_valid_reg;
  logic [WIDTH-1:0] m_data_reg;
  logic             sk_valid_reg;
  logic [WIDTH-1:0] sk_data_reg;
  logic             s_fire;

  assign s_ready = ~sk_valid_reg;
  assign s_fire  = s_valid & ~sk_valid_reg;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      sk_valid_reg <= 1'b0;
      sk_data_reg  <= '0;
    end else if (!m_valid_reg || m_ready) begin
      // Output slot frees up: refill from the skid entry first to keep order.
      // s_fire cannot coincide with a full skid entry (s_ready is low then).
      if (sk_valid_reg) begin
        m_valid_reg  <= 1'b1;
        m_data_reg   <= sk_data_reg;
        sk_valid_reg <= 1'b0;
      end else begin
        m_valid_reg <= s_fire;
        if (s_fire) m_data_reg <= s_data;
      end
    end else if (s_fire) begin
      // Output stalled: park the incoming word.
      sk_valid_reg <= 1'b1;
      sk_data_reg  <= s_data;
    end
  end

endmodule

// File: rtl/ip_tx_framer.sv
// ip_tx_framer: parses descriptor + payload bytes from a first-word-fall-through
// FIFO, issues one IP header handshake per frame and streams the payload as
// 8-bit AXI-Stream with TLAST on the final byte. Invalid lengths (0 or above
// MAX_PAYLOAD) are discarded and flagged on drop_pulse.
//   ap_clk, ap_rst_n                    clock, asynchronous active-low reset
//   din_V_dout/_empty_n/_read           byte FIFO interface (read = pop head)
//   tx_hdr_valid/_ready, tx_hdr         header handshake, 104-bit header bus
//   tx_payload_T*                       AXI-Stream payload output
//   drop_pulse                          one cycle per dropped frame
//   frame_cnt                           headers accepted, wrapping 16-bit
module ip_tx_framer
  import ip_tx_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 1480,
  parameter int         IP_HDR_LEN  = 20,
  parameter logic [5:0] DEF_DSCP    = 6'd0
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic [7:0]   din_V_dout,
  input  logic         din_V_empty_n,
  output logic         din_V_read,
  output logic         tx_hdr_valid,
  input  logic         tx_hdr_ready,
  output logic [103:0] tx_hdr,
  output logic         tx_payload_TVALID,
  input  logic         tx_payload_TREADY,
  output logic [7:0]   tx_payload_TDATA,
  output logic         tx_payload_TLAST,
  output logic         tx_payload_TKEEP,
  output logic         tx_payload_TSTRB,
  output logic         drop_pulse,
  output logic [15:0]  frame_cnt
);

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  logic [95:0] desc_reg, desc_next;
  logic [15:0] rem_reg, rem_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        drop_reg, drop_next;
  logic        rd;
  logic        sk_valid, sk_ready, sk_last;
  logic [8:0]  m_data;
  logic [15:0] new_len;

  // Length field as it will be once the byte at the FIFO head is shifted in.
  assign new_len = {desc_reg[7:0], din_V_dout};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg     <= S_DESC;
      idx_reg       <= '0;
      desc_reg      <= '0;
      rem_reg       <= '0;
      frame_cnt_reg <= '0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      desc_reg      <= desc_next;
      rem_reg       <= rem_next;
      frame_cnt_reg <= frame_cnt_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    desc_next      = desc_reg;
    rem_next       = rem_reg;
    frame_cnt_next = frame_cnt_reg;
    drop_next      = 1'b0;
    rd             = 1'b0;
    sk_valid       = 1'b0;
    sk_last        = 1'b0;
    case (state_reg)
      S_DESC: begin
        rd = din_V_empty_n;
        if (rd) begin
          desc_next = {desc_reg[87:0], din_V_dout};
          if (idx_reg == 4'(DESC_BYTES - 1)) begin
            idx_next = '0;
            if (new_len == 16'd0 || new_len > 16'(MAX_PAYLOAD)) begin
              state_next = S_DROP;
              rem_next   = new_len;
              drop_next  = 1'b1;
            end else begin
              state_next = S_HDR;
            end
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      S_HDR: begin
        if (tx_hdr_ready) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
          rem_next       = desc_reg[15:0];
          state_next     = S_PAY;
        end
      end
      S_PAY: begin
        rd       = din_V_empty_n & sk_ready;
        sk_valid = rd;
        sk_last  = (rem_reg == 16'd1);
        if (rd) begin
          rem_next = rem_reg - 16'd1;
          if (sk_last) state_next = S_DESC;
        end
      end
      S_DROP: begin
        if (rem_reg == 16'd0) begin
          state_next = S_DESC;
        end else begin
          rd = din_V_empty_n;
          if (rd) begin
            rem_next = rem_reg - 16'd1;
            if (rem_reg == 16'd1) state_next = S_DESC;
          end
        end
      end
      default: state_next = S_DESC;
    endcase
  end

  // Reset holds the state register in S_DESC, where reads follow empty_n;
  // gate so no pop is requested while reset is asserted.
  assign din_V_read   = rd & ap_rst_n;
  assign tx_hdr_valid = (state_reg == S_HDR);
  assign tx_hdr       = tx_hdr_valid
                      ? pack_hdr(desc_reg[95:64], desc_reg[63:32], desc_reg[31:24],
                                 desc_reg[23:16], desc_reg[15:0] + 16'(IP_HDR_LEN),
                                 2'b00, DEF_DSCP)
                      : '0;
  assign drop_pulse   = drop_reg;
  assign frame_cnt    = frame_cnt_reg;

  axis_skid_buf #(
    .WIDTH(9)
  ) u_skid (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .s_valid (sk_valid),
    .s_ready (sk_ready),
    .s_data  ({sk_last, din_V_dout}),
    .m_valid (tx_payload_TVALID),
    .m_ready (tx_payload_TREADY),
    .m_data  (m_data)
  );

  assign tx_payload_TLAST = m_data[8];
  assign tx_payload_TDATA = m_data[7:0];
  assign tx_payload_TKEEP = 1'b1;
  assign tx_payload_TSTRB = 1'b1;

endmodule
